axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE
// AXI4 burst initiator for the simulation testbench: drives INCR read/write bursts into the
// axi_interconnect slave ports / axi_ram DDR model, the requester end of the memory path.
// Takes one command at a time (address, beat count, direction).
// Moves data through valid/ready stream ports and reports completion and error status.
// Used to preload/check DDR contents and generate traffic alongside the system master.
// PARAMETERS
// ADDR_W  32  AXI address width (set to DDR_ADDR_W)
// DATA_W  32  AXI data width; beat size fixed to DATA_W/8 bytes
// ID_W    1   AXI ID width
// ID      0   constant value driven on awid/arid
// PORTS
// clk           in   1         clock
// rst           in   1         asynchronous reset, active-low
// cmd_valid     in   1         command request
// cmd_ready     out  1         command accepted when both high
// cmd_we        in   1         1=write burst, 0=read burst
// cmd_addr      in   ADDR_W    start byte address
// cmd_len       in   8         beats-1 (AXI LEN encoding)
// wr_valid/wr_ready  in/out 1  write data stream handshake
// wr_data/wr_strb    in  DATA_W, DATA_W/8  write beat data/byte strobes
// rd_valid/rd_ready  out/in 1  read data stream handshake
// rd_data/rd_last    out DATA_W, 1         read beat data / final beat
// done          out  1         1-cycle pulse when command finishes
// err           out  1         valid with done: 1=rejected or non-OKAY response
// m_axi_aw*     out  awid[ID_W] awaddr[ADDR_W] awlen[8] awsize[3] awburst[2] awlock[1]
//                    awcache[4] awprot[3] awqos[4] awvalid; in awready
// m_axi_w*      out  wdata[DATA_W] wstrb[DATA_W/8] wlast wvalid; in wready
// m_axi_b*      in   bid[ID_W] bresp[2] bvalid; out bready
// m_axi_ar*     out  same field set as aw*; in arready
// m_axi_r*      in   rid[ID_W] rdata[DATA_W] rresp[2] rlast rvalid; out rready
// BEHAVIOUR
// - Reset (rst low, async): state IDLE, beat counter 0, err flag 0.
//   All outputs 0, including cmd_ready, done, every valid and every ready.
//   Reset mid-burst aborts immediately; no completion is reported.
// - FSM: IDLE -> (WADDR->WDATA->WRESP | RADDR->RDATA) -> DONE -> IDLE.
// - IDLE: cmd_ready=1. On accept, command fields are registered.
//   Reject if cmd_addr[1:0]!=0 or addr[11:0]+(len+1)*4 > 4096; a rejected command
//   goes to DONE with err=1 and issues no AXI traffic.
// - Fixed fields: awburst/arburst=INCR (2'b01), size=log2(DATA_W/8), lock=0, cache=4'b0011,
//   prot=0, qos=0, id=ID.
// - WADDR/RADDR: *valid held high with stable addr/len until *ready. Exactly one cycle
//   later the FSM enters WDATA/RDATA. No outstanding overlap.
// - WDATA: wvalid=wr_valid, wr_ready=wready (combinational pass-through, zero latency).
//   wlast=1 when counter==len. Counter increments per wvalid&wready.
//   On the last beat go to WRESP.
// - WRESP: bready=1. On bvalid, err |= (bresp!=OKAY); go to DONE.
// - RDATA: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=rlast.
//   err |= (rresp!=OKAY) per beat. err |= rlast mismatch with counter==len.
//   Exit on the beat where counter==len.
// - DONE: done=1 for exactly 1 cycle, err valid; err cleared on the next accept.
// - wr_ready=0 and rd_valid=0 outside WDATA/RDATA. cmd_ready=0 outside IDLE.
// - len=0 is a single beat with wlast/rlast on the first beat. len=255 is 256 beats;
//   the counter is 8-bit and never wraps within a burst.
// TESTING
// 1. Write addr 0x100, len 3, data 0..3, strb 0xF.
//    Expect: awaddr=0x100, awlen=3, wlast only on beat 4, done with err=0.
// 2. Read back 0x100, len 3.
//    Expect: rd_data=0,1,2,3; rd_last on beat 4; done with err=0.
// 3. len=0 write then read at 0x0, data 0xDEADBEEF.
//    Expect: single beat with wlast=1/rd_last=1; readback 0xDEADBEEF.
// 4. cmd_addr=0x102 (unaligned), then addr 0xFF8 len 3 (crosses 4KB).
//    Expect: each done with err=1; awvalid/arvalid never asserted.
// 5. 16-beat write+read with random wr_valid/rd_ready/awready stalls.
//    Expect: data order intact, exactly 16 handshakes per burst.
// 6. Assert rst low mid-WDATA (beat 2 of 4).
//    Expect: outputs 0 asynchronously; after release cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst initiator: accepts one read or write command at a time, streams the
// beats through valid/ready ports and reports completion with an error flag.
module axi_burst_master #(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32,
  parameter int              ID_W   = 1,
  parameter logic [ID_W-1:0] ID     = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [7:0]          cmd_len_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_strb_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_last_o,
  output logic                done_o,
  output logic                err_o,
  output logic [ID_W-1:0]     m_axi_awid_o,
  output logic [ADDR_W-1:0]   m_axi_awaddr_o,
  output logic [7:0]          m_axi_awlen_o,
  output logic [2:0]          m_axi_awsize_o,
  output logic [1:0]          m_axi_awburst_o,
  output logic                m_axi_awlock_o,
  output logic [3:0]          m_axi_awcache_o,
  output logic [2:0]          m_axi_awprot_o,
  output logic [3:0]          m_axi_awqos_o,
  output logic                m_axi_awvalid_o,
  input  logic                m_axi_awready_i,
  output logic [DATA_W-1:0]   m_axi_wdata_o,
  output logic [DATA_W/8-1:0] m_axi_wstrb_o,
  output logic                m_axi_wlast_o,
  output logic                m_axi_wvalid_o,
  input  logic                m_axi_wready_i,
  input  logic [ID_W-1:0]     m_axi_bid_i,
  input  logic [1:0]          m_axi_bresp_i,
  input  logic                m_axi_bvalid_i,
  output logic                m_axi_bready_o,
  output logic [ID_W-1:0]     m_axi_arid_o,
  output logic [ADDR_W-1:0]   m_axi_araddr_o,
  output logic [7:0]          m_axi_arlen_o,
  output logic [2:0]          m_axi_arsize_o,
  output logic [1:0]          m_axi_arburst_o,
  output logic                m_axi_arlock_o,
  output logic [3:0]          m_axi_arcache_o,
  output logic [2:0]          m_axi_arprot_o,
  output logic [3:0]          m_axi_arqos_o,
  output logic                m_axi_arvalid_o,
  input  logic                m_axi_arready_i,
  input  logic [ID_W-1:0]     m_axi_rid_i,
  input  logic [DATA_W-1:0]   m_axi_rdata_i,
  input  logic [1:0]          m_axi_rresp_i,
  input  logic                m_axi_rlast_i,
  input  logic                m_axi_rvalid_i
  ,output logic               m_axi_rready_o
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [2:0] SIZE   = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              awActive, arActive, wActive, rActive;
  logic              lastBeat, reject;
  logic [31:0]       pageEnd;
  logic              unusedIds;

  assign unusedIds = ^{m_axi_bid_i, m_axi_rid_i};

  // A burst must start beat-aligned and must not run past the end of its 4 KB page.
  assign pageEnd = 32'(cmd_addr_i[11:0]) + (32'(cmd_len_i) + 32'd1) * 32'(STRB_W);
  assign reject  = ((cmd_addr_i & ADDR_W'(STRB_W - 1)) != '0) || (pageEnd > 32'd4096);

  assign awActive = (state_q == WADDR);
  assign arActive = (state_q == RADDR);
  assign wActive  = (state_q == WDATA);
  assign rActive  = (state_q == RDATA);
  assign lastBeat = (cnt_q == len_q);

  // Qualified with rst_ni so cmd_ready drops the moment reset is asserted.
  assign cmd_ready_o = (state_q == IDLE) && rst_ni;
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

  assign m_axi_awvalid_o = awActive;
  assign m_axi_awid_o    = awActive ? ID : '0;
  assign m_axi_awaddr_o  = awActive ? addr_q : '0;
  assign m_axi_awlen_o   = awActive ? len_q : '0;
  assign m_axi_awsize_o  = awActive ? SIZE : '0;
  assign m_axi_awburst_o = awActive ? 2'b01 : '0;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = awActive ? 4'b0011 : '0;
  assign m_axi_awprot_o  = '0;
  assign m_axi_awqos_o   = '0;

  assign m_axi_arvalid_o = arActive;
  assign m_axi_arid_o    = arActive ? ID : '0;
  assign m_axi_araddr_o  = arActive ? addr_q : '0;
  assign m_axi_arlen_o   = arActive ? len_q : '0;
  assign m_axi_arsize_o  = arActive ? SIZE : '0;
  assign m_axi_arburst_o = arActive ? 2'b01 : '0;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = arActive ? 4'b0011 : '0;
  assign m_axi_arprot_o  = '0;
  assign m_axi_arqos_o   = '0;

  // Data phases are zero-latency pass-throughs between the stream ports and AXI.
  assign m_axi_wvalid_o = wActive && wr_valid_i;
  assign wr_ready_o     = wActive && m_axi_wready_i;
  assign m_axi_wdata_o  = wActive ? wr_data_i : '0;
  assign m_axi_wstrb_o  = wActive ? wr_strb_i : '0;
  assign m_axi_wlast_o  = wActive && lastBeat;
  assign m_axi_bready_o = (state_q == WRESP);

  assign rd_valid_o     = rActive && m_axi_rvalid_i;
  assign m_axi_rready_o = rActive && rd_ready_i;
  assign rd_data_o      = rActive ? m_axi_rdata_i : '0;
  assign rd_last_o      = rActive && m_axi_rlast_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          len_d   = cmd_len_i;
          cnt_d   = '0;
          err_d   = reject;
          state_d = reject ? DONE : (cmd_we_i ? WADDR : RADDR);
        end
      end
      WADDR: if (m_axi_awready_i) state_d = WDATA;
      WDATA: begin
        if (wr_valid_i && m_axi_wready_i) begin
          if (lastBeat) state_d = WRESP;
          else          cnt_d   = cnt_q + 8'd1;
        end
      end
      WRESP: begin
        if (m_axi_bvalid_i) begin
          err_d   = err_q | (m_axi_bresp_i != 2'b00);
          state_d = DONE;
        end
      end
      RADDR: if (m_axi_arready_i) state_d = RDATA;
      RDATA: begin
        // A misplaced rlast is flagged but the burst still ends on the counted beat.
        if (m_axi_rvalid_i && rd_ready_i) begin
          err_d = err_q | (m_axi_rresp_i != 2'b00) | (m_axi_rlast_i != lastBeat);
          if (lastBeat) state_d = DONE;
          else          cnt_d   = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
